// File: rtl/pb_pkg.sv
// Shared types and constants for the pushbutton front end.
// State encodings and default qualification counts.
package pb_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'b00,
        S_CHK_HIGH = 2'b01,
        S_HIGH     = 2'b10,
        S_CHK_LOW  = 2'b11
    } pb_state_t;

    localparam int STABLE_SIM   = 16;
    // 10 ms at 100 MHz; fits the default 20-bit counter
    localparam int STABLE_BOARD = 1_000_000;

endpackage

// File: rtl/pb_debouncer_if.sv
// Button-side bundle: raw level in, clean level and strobes out.
// The debouncer takes the slave view; the driver of pb_raw takes master.
interface pb_debouncer_if;

    logic pb_raw;
    logic pb_clean;
    logic pb_rise;
    logic pb_fall;
    logic busy;

    modport master (
        output pb_raw,
        input  pb_clean,
        input  pb_rise,
        input  pb_fall,
        input  busy
    );

    modport slave (
        input  pb_raw,
        output pb_clean,
        output pb_rise,
        output pb_fall,
        output busy
    );

endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, async reset to 0.
// Shared by all lab buttons and switches.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pb_debouncer.sv
// Pushbutton debouncer: 2FF sync followed by a stable-count FSM.
// Clean level, rise/fall strobes and busy are registered from next state.
module pb_debouncer
    import pb_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 20
) (
    input  logic           clk,
    input  logic           rst,
    pb_debouncer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pb_state_t        state;
    pb_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pb_sync;
    logic             rise_nxt;
    logic             fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pb_raw),
        .q   (pb_sync)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            S_LOW: begin
                if (pb_sync) begin
                    state_nxt = S_CHK_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_CHK_HIGH: begin
                if (!pb_sync) begin
                    state_nxt = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!pb_sync) begin
                    state_nxt = S_CHK_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_CHK_LOW: begin
                if (pb_sync) begin
                    state_nxt = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_LOW;
            cnt          <= '0;
            bus.pb_clean <= 1'b0;
            bus.pb_rise  <= 1'b0;
            bus.pb_fall  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            // level tracks the accepted side, so aborts never move it
            bus.pb_clean <= (state_nxt == S_HIGH) ||
                            (state_nxt == S_CHK_LOW);
            bus.busy     <= (state_nxt == S_CHK_HIGH) ||
                            (state_nxt == S_CHK_LOW);
            bus.pb_rise  <= rise_nxt;
            bus.pb_fall  <= fall_nxt;
        end
    end

endmodule

// File: tb/tb_pb_debouncer.sv
// Self-checking bench for pb_debouncer with a run-length reference model.
// Expected outputs are queued per edge and compared after the edge.
module tb_pb_debouncer;
    import pb_pkg::*;

    localparam int N = STABLE_SIM;

    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pb_debouncer_if bus ();

    pb_debouncer #(
        .STABLE_CYCLES (N),
        .CNT_W         (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic m_s1, m_s2, m_lvl;
    int   m_run;

    int edge_n, n_rise, n_fall, n_busy, rise_edge, fall_edge;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_lvl = 1'b0;
        m_run = 0;
    endtask

    // Accepted level flips after N consecutive opposite synced samples
    task automatic model_edge(input logic raw, output exp_t e);
        logic smp;
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        e    = '0;
        if (smp != m_lvl) begin
            m_run++;
            if (m_run == N) begin
                m_lvl  = smp;
                m_run  = 0;
                e.rise = smp;
                e.fall = !smp;
            end
        end else begin
            m_run = 0;
        end
        e.clean = m_lvl;
        e.busy  = (m_run != 0);
    endtask

    task automatic phase();
        edge_n    = 0;
        n_rise    = 0;
        n_fall    = 0;
        n_busy    = 0;
        rise_edge = -1;
        fall_edge = -1;
    endtask

    task automatic step(input logic raw);
        exp_t e;
        bus.pb_raw = raw;
        model_edge(raw, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("clean", int'(bus.pb_clean), int'(e.clean));
        check("rise", int'(bus.pb_rise), int'(e.rise));
        check("fall", int'(bus.pb_fall), int'(e.fall));
        check("busy", int'(bus.busy), int'(e.busy));
        if (bus.pb_rise) begin
            n_rise++;
            rise_edge = edge_n;
        end
        if (bus.pb_fall) begin
            n_fall++;
            fall_edge = edge_n;
        end
        if (bus.busy) n_busy++;
        edge_n++;
    endtask

    task automatic steps(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(raw);
    endtask

    function automatic int outs();
        return int'({bus.pb_clean, bus.pb_rise, bus.pb_fall, bus.busy});
    endfunction

    initial begin
        logic [5:0] bounce;
        bus.pb_raw = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        phase();
        steps(1'b0, 3);

        // clean press
        phase();
        steps(1'b1, 40);
        check("press_lat", rise_edge, N + 1);
        check("press_nrise", n_rise, 1);
        check("press_busy", n_busy, N - 1);
        check("press_nfall", n_fall, 0);
        check("press_level", int'(bus.pb_clean), 1);

        // release
        phase();
        steps(1'b0, 30);
        check("rel_lat", fall_edge, N + 1);
        check("rel_nfall", n_fall, 1);
        check("rel_nrise", n_rise, 0);

        // glitch rejected
        phase();
        steps(1'b1, 10);
        steps(1'b0, 20);
        check("glitch_nrise", n_rise, 0);
        check("glitch_nfall", n_fall, 0);
        check("glitch_busy", n_busy, 10);
        check("glitch_idle", int'(bus.busy), 0);

        // bouncy press; sent LSB first: 1,0,1,1,0,1
        phase();
        bounce = 6'b101101;
        for (int i = 0; i < 6; i++) step(bounce[i]);
        steps(1'b1, 30);
        check("bounce_lat", rise_edge, 5 + N + 1);
        check("bounce_nrise", n_rise, 1);
        check("bounce_nfall", n_fall, 0);
        steps(1'b0, 30);

        // boundary: one sample short
        phase();
        steps(1'b1, N - 1);
        steps(1'b0, 25);
        check("short_nrise", n_rise, 0);
        check("short_level", int'(bus.pb_clean), 0);

        // boundary: exactly enough
        phase();
        steps(1'b1, N);
        steps(1'b0, 25);
        check("exact_lat", rise_edge, N + 1);
        check("exact_nrise", n_rise, 1);
        check("exact_fall", fall_edge, 2 * N + 1);
        check("exact_nfall", n_fall, 1);

        // reset in the middle of a qualification
        phase();
        steps(1'b1, 8);
        check("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("rst_async", outs(), 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", outs(), 0);
        end
        rst = 1'b0;
        phase();
        steps(1'b1, 30);
        check("rst_lat", rise_edge, N + 1);
        check("rst_nrise", n_rise, 1);
        steps(1'b0, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
